// File: rtl/ibex_wb_queue_if.sv
// Bus bundle between ID/EX, the LSU response path, the register file
// and the in-order writeback queue.
interface ibex_wb_queue_if;
    logic        en_wb_i;
    logic [1:0]  instr_type_wb_i;
    logic [31:0] pc_id_i;
    logic        instr_is_compressed_id_i;
    logic        instr_perf_count_id_i;
    logic [4:0]  rf_waddr_id_i;
    logic [31:0] rf_wdata_id_i;
    logic        rf_we_id_i;
    logic [31:0] rf_wdata_lsu_i;
    logic        rf_we_lsu_i;
    logic        lsu_resp_valid_i;
    logic        lsu_resp_err_i;
    logic [4:0]  rd_addr_a_i;
    logic [4:0]  rd_addr_b_i;
    logic        ready_wb_o;
    logic        lsu_resp_ready_o;
    logic [4:0]  rf_waddr_wb_o;
    logic [31:0] rf_wdata_wb_o;
    logic        rf_we_wb_o;
    logic [31:0] pc_wb_o;
    logic        instr_done_wb_o;
    logic        outstanding_load_wb_o;
    logic        outstanding_store_wb_o;
    logic [3:0]  occupancy_o;
    logic        fwd_valid_a_o;
    logic        fwd_valid_b_o;
    logic [31:0] fwd_data_a_o;
    logic [31:0] fwd_data_b_o;
    logic        stall_a_o;
    logic        stall_b_o;
    logic        perf_instr_ret_wb_o;
    logic        perf_instr_ret_compressed_wb_o;

    modport slave (
        input  en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_id_i,
               instr_perf_count_id_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i,
               rf_wdata_lsu_i, rf_we_lsu_i, lsu_resp_valid_i, lsu_resp_err_i,
               rd_addr_a_i, rd_addr_b_i,
        output ready_wb_o, lsu_resp_ready_o, rf_waddr_wb_o, rf_wdata_wb_o,
               rf_we_wb_o, pc_wb_o, instr_done_wb_o, outstanding_load_wb_o,
               outstanding_store_wb_o, occupancy_o, fwd_valid_a_o, fwd_valid_b_o,
               fwd_data_a_o, fwd_data_b_o, stall_a_o, stall_b_o,
               perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o
    );

    modport master (
        output en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_id_i,
               instr_perf_count_id_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i,
               rf_wdata_lsu_i, rf_we_lsu_i, lsu_resp_valid_i, lsu_resp_err_i,
               rd_addr_a_i, rd_addr_b_i,
        input  ready_wb_o, lsu_resp_ready_o, rf_waddr_wb_o, rf_wdata_wb_o,
               rf_we_wb_o, pc_wb_o, instr_done_wb_o, outstanding_load_wb_o,
               outstanding_store_wb_o, occupancy_o, fwd_valid_a_o, fwd_valid_b_o,
               fwd_data_a_o, fwd_data_b_o, stall_a_o, stall_b_o,
               perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o
    );
endinterface

// File: rtl/ibex_wb_queue.sv
// In-order writeback queue: holds up to Depth issued instructions, retires
// at most one per cycle from the head, and offers forwarding/stall info for
// two operand read ports. Optional statistics outputs are enabled with the
// macro IBEX_WB_QUEUE_STATS_EN.
module ibex_wb_queue #(
    parameter int unsigned Depth    = 2,
    parameter bit          ResetAll = 1'b0
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    ibex_wb_queue_if.slave wb
`ifdef IBEX_WB_QUEUE_STATS_EN
    ,
    output logic [15:0]    stat_full_stall_o,
    output logic [3:0]     stat_max_occ_o
`endif
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [1:0] TypeLoad  = 2'd0;
    localparam logic [1:0] TypeStore = 2'd1;

    typedef struct packed {
        logic [1:0]  itype;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] pc;
        logic        compressed;
        logic        count;
    } entry_t;

    entry_t           mem_q [Depth];
    entry_t           new_entry;
    entry_t           head;
    logic [Depth-1:0] valid_q;
    logic [PtrW-1:0]  head_q, tail_q;
    logic [3:0]       count_q;
    logic             head_valid, head_is_load, head_is_store, head_is_ls;
    logic             head_done, ready, enq, lsu_ready;
    logic [4:0]       rd_addr [2];
    logic             hz_stall [2];
    logic             hz_fwd [2];
    logic [31:0]      hz_data [2];

    // Pointers wrap at Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head          = mem_q[head_q];
    assign head_valid    = valid_q[head_q];
    assign head_is_load  = (head.itype == TypeLoad);
    assign head_is_store = (head.itype == TypeStore);
    assign head_is_ls    = head_is_load | head_is_store;
    assign lsu_ready     = head_valid & head_is_ls;
    assign head_done     = head_valid & (~head_is_ls | (wb.lsu_resp_valid_i & lsu_ready));
    // A full queue still accepts when its head frees a slot this cycle.
    assign ready         = (count_q < 4'(Depth)) | head_done;
    assign enq           = wb.en_wb_i & ready;

    assign new_entry = '{itype: wb.instr_type_wb_i, waddr: wb.rf_waddr_id_i,
                         wdata: wb.rf_wdata_id_i, we: wb.rf_we_id_i, pc: wb.pc_id_i,
                         compressed: wb.instr_is_compressed_id_i,
                         count: wb.instr_perf_count_id_i};

    assign wb.ready_wb_o       = ready;
    assign wb.lsu_resp_ready_o = lsu_ready;
    assign wb.instr_done_wb_o  = head_done;
    assign wb.occupancy_o      = count_q;
    assign wb.rf_waddr_wb_o    = head_valid ? head.waddr : 5'd0;
    assign wb.pc_wb_o          = head_valid ? head.pc : 32'd0;
    assign wb.perf_instr_ret_wb_o = head_done & head.count &
                                    ~(wb.lsu_resp_valid_i & wb.lsu_resp_err_i);
    assign wb.perf_instr_ret_compressed_wb_o = wb.perf_instr_ret_wb_o & head.compressed;

    // Register file write from the head: loads take LSU data, stores never write.
    always_comb begin
        wb.rf_we_wb_o    = 1'b0;
        wb.rf_wdata_wb_o = 32'd0;
        if (head_is_load) begin
            wb.rf_we_wb_o = head_done & wb.rf_we_lsu_i;
            if (wb.rf_we_wb_o) wb.rf_wdata_wb_o = wb.rf_wdata_lsu_i;
        end else if (!head_is_store) begin
            wb.rf_we_wb_o = head_done & head.we;
            if (wb.rf_we_wb_o) wb.rf_wdata_wb_o = head.wdata;
        end
    end

    // Summarise which kinds of memory operations are still in flight.
    always_comb begin
        wb.outstanding_load_wb_o  = 1'b0;
        wb.outstanding_store_wb_o = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            if (valid_q[i] && mem_q[i].itype == TypeLoad)  wb.outstanding_load_wb_o  = 1'b1;
            if (valid_q[i] && mem_q[i].itype == TypeStore) wb.outstanding_store_wb_o = 1'b1;
        end
    end

    assign rd_addr[0] = wb.rd_addr_a_i;
    assign rd_addr[1] = wb.rd_addr_b_i;

    // Walk entries oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        logic [PtrW:0]   idx;
        logic [PtrW-1:0] slot;
        idx  = '0;
        slot = '0;
        for (int p = 0; p < 2; p++) begin
            hz_stall[p] = 1'b0;
            hz_fwd[p]   = 1'b0;
            hz_data[p]  = 32'd0;
            for (int i = 0; i < Depth; i++) begin
                idx = {1'b0, head_q} + (PtrW + 1)'(i);
                if (idx >= (PtrW + 1)'(Depth)) idx = idx - (PtrW + 1)'(Depth);
                slot = idx[PtrW-1:0];
                if (valid_q[slot] && rd_addr[p] != 5'd0 && mem_q[slot].waddr == rd_addr[p] &&
                    (mem_q[slot].we || mem_q[slot].itype == TypeLoad)) begin
                    hz_stall[p] = (mem_q[slot].itype == TypeLoad);
                    hz_fwd[p]   = (mem_q[slot].itype != TypeLoad);
                    hz_data[p]  = (mem_q[slot].itype != TypeLoad) ? mem_q[slot].wdata : 32'd0;
                end
            end
        end
    end

    assign wb.stall_a_o     = hz_stall[0];
    assign wb.stall_b_o     = hz_stall[1];
    assign wb.fwd_valid_a_o = hz_fwd[0];
    assign wb.fwd_valid_b_o = hz_fwd[1];
    assign wb.fwd_data_a_o  = hz_data[0];
    assign wb.fwd_data_b_o  = hz_data[1];

    // Control state: valid bits, pointers and occupancy; enqueue wins over retire on the same slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (head_done) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= ptr_inc(head_q);
            end
            if (enq) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= ptr_inc(tail_q);
            end
            count_q <= count_q + 4'(enq) - 4'(head_done);
        end
    end

    if (ResetAll) begin : g_payload_rst
        // Payload capture at the tail, cleared on reset.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
            end else if (enq) begin
                mem_q[tail_q] <= new_entry;
            end
        end
    end else begin : g_payload_norst
        // Payload capture at the tail; contents are qualified by valid bits.
        always_ff @(posedge clk_i) begin
            if (enq) mem_q[tail_q] <= new_entry;
        end
    end

`ifdef IBEX_WB_QUEUE_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Count refused enqueue cycles (saturating) and track the occupancy high-water mark.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_full_stall_o <= '0;
            stat_max_occ_o    <= '0;
        end else begin
            if (wb.en_wb_i && !ready) stat_full_stall_o <= sat_inc16(stat_full_stall_o);
            if (count_q > stat_max_occ_o) stat_max_occ_o <= count_q;
        end
    end
`endif

    // The LSU must hold its response until the queue asks for it.
    a_resp_when_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
        wb.lsu_resp_valid_i |-> lsu_ready);
endmodule

// File: tb/tb_ibex_wb_queue.sv
// Scoreboard bench for ibex_wb_queue: a Depth=2 and a Depth=3 instance.
// Expected retirements are queued at issue time; monitors compare on retire.
module tb_ibex_wb_queue;
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ibex_wb_queue_if ifa ();
    ibex_wb_queue_if ifb ();

`ifdef IBEX_WB_QUEUE_STATS_EN
    logic [15:0] st_stall_a, st_stall_b;
    logic [3:0]  st_occ_a, st_occ_b;
    ibex_wb_queue #(.Depth(2)) u_dut_a (.clk_i(clk), .rst_ni(rst_ni), .wb(ifa),
        .stat_full_stall_o(st_stall_a), .stat_max_occ_o(st_occ_a));
    ibex_wb_queue #(.Depth(3)) u_dut_b (.clk_i(clk), .rst_ni(rst_ni), .wb(ifb),
        .stat_full_stall_o(st_stall_b), .stat_max_occ_o(st_occ_b));
`else
    ibex_wb_queue #(.Depth(2)) u_dut_a (.clk_i(clk), .rst_ni(rst_ni), .wb(ifa));
    ibex_wb_queue #(.Depth(3)) u_dut_b (.clk_i(clk), .rst_ni(rst_ni), .wb(ifb));
`endif

    logic [71:0] exp_a [$];
    logic [71:0] exp_b [$];
    logic [71:0] e_a, e_b, act_a, act_b;

    function automatic logic [71:0] pack(input logic [31:0] pc, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd,
                                         input logic perf, input logic perfc);
        return {pc, we, wa, wd, perf, perfc};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_a();
        ifa.en_wb_i = 0; ifa.instr_type_wb_i = 0; ifa.pc_id_i = 0;
        ifa.instr_is_compressed_id_i = 0; ifa.instr_perf_count_id_i = 0;
        ifa.rf_waddr_id_i = 0; ifa.rf_wdata_id_i = 0; ifa.rf_we_id_i = 0;
        ifa.rf_wdata_lsu_i = 0; ifa.rf_we_lsu_i = 0;
        ifa.lsu_resp_valid_i = 0; ifa.lsu_resp_err_i = 0;
    endtask

    task automatic idle_b();
        ifb.en_wb_i = 0; ifb.instr_type_wb_i = 0; ifb.pc_id_i = 0;
        ifb.instr_is_compressed_id_i = 0; ifb.instr_perf_count_id_i = 0;
        ifb.rf_waddr_id_i = 0; ifb.rf_wdata_id_i = 0; ifb.rf_we_id_i = 0;
        ifb.rf_wdata_lsu_i = 0; ifb.rf_we_lsu_i = 0;
        ifb.lsu_resp_valid_i = 0; ifb.lsu_resp_err_i = 0;
    endtask

    task automatic enq_a(input logic [1:0] t, input logic [4:0] wa, input logic [31:0] wd,
                         input logic we, input logic [31:0] pc, input logic c, input logic cnt);
        ifa.en_wb_i = 1; ifa.instr_type_wb_i = t; ifa.rf_waddr_id_i = wa;
        ifa.rf_wdata_id_i = wd; ifa.rf_we_id_i = we; ifa.pc_id_i = pc;
        ifa.instr_is_compressed_id_i = c; ifa.instr_perf_count_id_i = cnt;
    endtask

    task automatic enq_b(input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc);
        ifb.en_wb_i = 1; ifb.instr_type_wb_i = 2'd2; ifb.rf_waddr_id_i = wa;
        ifb.rf_wdata_id_i = wd; ifb.rf_we_id_i = 1; ifb.pc_id_i = pc;
        ifb.instr_is_compressed_id_i = 0; ifb.instr_perf_count_id_i = 1;
    endtask

    // Monitor for the Depth=2 instance: every retirement must match the next expected one.
    always @(negedge clk) begin
        if (rst_ni) begin
            act_a = {ifa.pc_wb_o, ifa.rf_we_wb_o, ifa.rf_waddr_wb_o, ifa.rf_wdata_wb_o,
                     ifa.perf_instr_ret_wb_o, ifa.perf_instr_ret_compressed_wb_o};
            if (ifa.instr_done_wb_o) begin
                n_tests++;
                if (exp_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL retire_a: unexpected retire got 0x%0h", act_a);
                end else begin
                    e_a = exp_a.pop_front();
                    if (act_a !== e_a) begin
                        n_fail++;
                        $display("FAIL retire_a: got 0x%0h expected 0x%0h", act_a, e_a);
                    end
                end
            end else if (ifa.rf_we_wb_o) begin
                n_tests++;
                n_fail++;
                $display("FAIL rf_we_a: write without retire got 0x%0h", act_a);
            end
        end
    end

    // Monitor for the Depth=3 instance.
    always @(negedge clk) begin
        if (rst_ni) begin
            act_b = {ifb.pc_wb_o, ifb.rf_we_wb_o, ifb.rf_waddr_wb_o, ifb.rf_wdata_wb_o,
                     ifb.perf_instr_ret_wb_o, ifb.perf_instr_ret_compressed_wb_o};
            if (ifb.instr_done_wb_o) begin
                n_tests++;
                if (exp_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL retire_b: unexpected retire got 0x%0h", act_b);
                end else begin
                    e_b = exp_b.pop_front();
                    if (act_b !== e_b) begin
                        n_fail++;
                        $display("FAIL retire_b: got 0x%0h expected 0x%0h", act_b, e_b);
                    end
                end
            end else if (ifb.rf_we_wb_o) begin
                n_tests++;
                n_fail++;
                $display("FAIL rf_we_b: write without retire got 0x%0h", act_b);
            end
        end
    end

    initial begin
        idle_a();
        idle_b();
        ifa.rd_addr_a_i = 0; ifa.rd_addr_b_i = 0;
        ifb.rd_addr_a_i = 0; ifb.rd_addr_b_i = 0;

        // Reset state
        repeat (2) mid();
        check("rst_ready_a", 32'(ifa.ready_wb_o), 1);
        check("rst_occ_a", 32'(ifa.occupancy_o), 0);
        check("rst_rf_we_a", 32'(ifa.rf_we_wb_o), 0);
        check("rst_lsu_ready_a", 32'(ifa.lsu_resp_ready_o), 0);
        check("rst_pc_a", ifa.pc_wb_o, 0);
        check("rst_ready_b", 32'(ifb.ready_wb_o), 1);
        rst_ni = 1'b1;
        tick();

        // Single "other" instruction retires the cycle after enqueue
        enq_a(2'd2, 5'd5, 32'hA5A5_0001, 1, 32'h100, 1, 1);
        exp_a.push_back(pack(32'h100, 1, 5'd5, 32'hA5A5_0001, 1, 1));
        mid();
        check("t1_occ_before", 32'(ifa.occupancy_o), 0);
        tick();
        idle_a();
        mid();
        check("t1_occ", 32'(ifa.occupancy_o), 1);
        check("t1_done", 32'(ifa.instr_done_wb_o), 1);
        check("t1_rf_we", 32'(ifa.rf_we_wb_o), 1);
        check("t1_waddr", 32'(ifa.rf_waddr_wb_o), 5);
        tick();
        mid();
        check("t1_occ_after", 32'(ifa.occupancy_o), 0);
        tick();

        // Load x7 then other x7=0x11: forward youngest, then ordered writes
        enq_a(2'd0, 5'd7, 32'h0, 1, 32'h200, 0, 1);
        exp_a.push_back(pack(32'h200, 1, 5'd7, 32'h22, 1, 0));
        tick();
        enq_a(2'd2, 5'd7, 32'h11, 1, 32'h204, 0, 1);
        exp_a.push_back(pack(32'h204, 1, 5'd7, 32'h11, 1, 0));
        tick();
        idle_a();
        ifa.rd_addr_a_i = 7; ifa.rd_addr_b_i = 7;
        mid();
        check("t2_fwd_valid_a", 32'(ifa.fwd_valid_a_o), 1);
        check("t2_fwd_data_a", ifa.fwd_data_a_o, 32'h11);
        check("t2_stall_a", 32'(ifa.stall_a_o), 0);
        check("t2_fwd_valid_b", 32'(ifa.fwd_valid_b_o), 1);
        check("t2_full_ready", 32'(ifa.ready_wb_o), 0);
        check("t2_out_load", 32'(ifa.outstanding_load_wb_o), 1);
        tick();
        ifa.lsu_resp_valid_i = 1; ifa.rf_wdata_lsu_i = 32'h22; ifa.rf_we_lsu_i = 1;
        mid();
        check("t2_fwd_while_load_retires", ifa.fwd_data_a_o, 32'h11);
        tick();
        idle_a();
        mid();
        check("t2_fwd_while_other_retires", 32'(ifa.fwd_valid_a_o), 1);
        tick();
        mid();
        check("t2_fwd_gone", 32'(ifa.fwd_valid_a_o), 0);
        check("t2_occ_empty", 32'(ifa.occupancy_o), 0);
        tick();

        // Two loads fill the queue; retire + enqueue in the same cycle
        ifa.rd_addr_a_i = 9; ifa.rd_addr_b_i = 0;
        enq_a(2'd0, 5'd9, 32'h0, 1, 32'h300, 0, 1);
        exp_a.push_back(pack(32'h300, 1, 5'd9, 32'h33, 1, 0));
        tick();
        enq_a(2'd0, 5'd10, 32'h0, 1, 32'h304, 0, 1);
        exp_a.push_back(pack(32'h304, 0, 5'd10, 32'h0, 1, 0));
        tick();
        idle_a();
        mid();
        check("t3_ready_full", 32'(ifa.ready_wb_o), 0);
        check("t3_occ_full", 32'(ifa.occupancy_o), 2);
        check("t3_stall_a", 32'(ifa.stall_a_o), 1);
        check("t3_fwd_valid_a", 32'(ifa.fwd_valid_a_o), 0);
        check("t3_stall_b_x0", 32'(ifa.stall_b_o), 0);
        check("t3_lsu_ready", 32'(ifa.lsu_resp_ready_o), 1);
        tick();
        ifa.lsu_resp_valid_i = 1; ifa.rf_wdata_lsu_i = 32'h33; ifa.rf_we_lsu_i = 1;
        enq_a(2'd2, 5'd11, 32'h44, 1, 32'h308, 0, 1);
        exp_a.push_back(pack(32'h308, 1, 5'd11, 32'h44, 1, 0));
        mid();
        check("t3_ready_on_retire", 32'(ifa.ready_wb_o), 1);
        tick();
        idle_a();
        ifa.lsu_resp_valid_i = 1; ifa.rf_wdata_lsu_i = 32'h55; ifa.rf_we_lsu_i = 0;
        mid();
        check("t3_occ_stays", 32'(ifa.occupancy_o), 2);
        tick();
        idle_a();
        mid();
        check("t3_occ_one", 32'(ifa.occupancy_o), 1);
        tick();
        mid();
        check("t3_occ_empty", 32'(ifa.occupancy_o), 0);
        tick();

        // Store with error response: retires, no rf write, not counted
        ifa.rd_addr_a_i = 0;
        enq_a(2'd1, 5'd3, 32'hDEAD, 1, 32'h400, 1, 1);
        exp_a.push_back(pack(32'h400, 0, 5'd3, 32'h0, 0, 0));
        tick();
        idle_a();
        ifa.lsu_resp_valid_i = 1; ifa.lsu_resp_err_i = 1;
        ifa.rf_we_lsu_i = 1; ifa.rf_wdata_lsu_i = 32'h77;
        mid();
        check("t4_out_store", 32'(ifa.outstanding_store_wb_o), 1);
        check("t4_done", 32'(ifa.instr_done_wb_o), 1);
        check("t4_perf", 32'(ifa.perf_instr_ret_wb_o), 0);
        check("t4_rf_we", 32'(ifa.rf_we_wb_o), 0);
        tick();
        idle_a();

        // Depth=3: seven back-to-back writers across pointer wrap
        for (int i = 1; i <= 7; i++) begin
            enq_b(5'(i), 32'h1000 + 32'(i), 32'h500 + 32'(4 * i));
            exp_b.push_back(pack(32'h500 + 32'(4 * i), 1, 5'(i), 32'h1000 + 32'(i), 1, 0));
            tick();
        end
        idle_b();
        mid();
        tick();
        mid();
        check("t5_occ_empty_b", 32'(ifb.occupancy_o), 0);
        check("t5_all_retired_b", 32'(exp_b.size()), 0);
        tick();

        // Reset with two pending loads discards them
        enq_a(2'd0, 5'd12, 32'h0, 1, 32'h600, 0, 1);
        tick();
        enq_a(2'd0, 5'd13, 32'h0, 1, 32'h604, 0, 1);
        tick();
        idle_a();
        mid();
        check("t6_occ_before_rst", 32'(ifa.occupancy_o), 2);
        rst_ni = 1'b0;
        #1;
        check("t6_occ_rst", 32'(ifa.occupancy_o), 0);
        check("t6_ready_rst", 32'(ifa.ready_wb_o), 1);
        mid();
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            mid();
            check("t6_no_rf_we", 32'(ifa.rf_we_wb_o), 0);
        end
        check("t6_occ_after", 32'(ifa.occupancy_o), 0);
        check("all_retired_a", 32'(exp_a.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ibex_wb_queue.md
Name: ibex_wb_queue

Overview:
Parametrised in-order writeback queue that replaces the single-entry writeback register between ID/EX and the register file. It holds up to Depth issued instructions, so several loads/stores can be outstanding. Entries retire strictly in order, at most one per cycle. It also provides per-operand hazard detection and forwarding for two read ports.

Parameters:
Depth, 2, number of queue entries; legal range 1..8.
ResetAll, 1'b0, when 1 every payload register is asynchronously reset to 0; when 0 only control state is reset.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
en_wb_i  in  1  enqueue request from ID/EX; accepted when ready_wb_o=1
instr_type_wb_i  in  2  0=load, 1=store, 2=other (3 treated as other)
pc_id_i  in  32  PC of enqueued instruction
instr_is_compressed_id_i  in  1  compressed flag
instr_perf_count_id_i  in  1  counts toward instret
rf_waddr_id_i  in  5  destination register
rf_wdata_id_i  in  32  result data (ignored for loads)
rf_we_id_i  in  1  destination write enable
rf_wdata_lsu_i  in  32  load response data
rf_we_lsu_i  in  1  load response writes the register file
lsu_resp_valid_i  in  1  LSU response valid
lsu_resp_err_i  in  1  LSU response error
rd_addr_a_i  in  5  operand A register address for hazard check
rd_addr_b_i  in  5  operand B register address for hazard check
ready_wb_o  out  1  queue can accept en_wb_i this cycle
lsu_resp_ready_o  out  1  head entry is a load/store awaiting a response
rf_waddr_wb_o  out  5  register file write address
rf_wdata_wb_o  out  32  register file write data
rf_we_wb_o  out  1  register file write enable
pc_wb_o  out  32  PC of head entry
instr_done_wb_o  out  1  head entry retires this cycle
outstanding_load_wb_o  out  1  any valid load entry
outstanding_store_wb_o  out  1  any valid store entry
occupancy_o  out  4  number of valid entries
fwd_valid_a_o / fwd_valid_b_o  out  1  forwarding data available for the operand
fwd_data_a_o / fwd_data_b_o  out  32  forwarded data
stall_a_o / stall_b_o  out  1  operand depends on a pending load
perf_instr_ret_wb_o  out  1  counted instruction retired without error
perf_instr_ret_compressed_wb_o  out  1  retired counted instruction was compressed

Behaviour:
- Storage:
  - Circular buffer with head/tail pointers that wrap at Depth (Depth need not be a power of two).
  - Each entry has a valid bit plus payload: type, waddr, wdata, we, pc, compressed, count.
- Reset:
  - All valid bits, pointers and the count clear.
  - All outputs reset to 0, except ready_wb_o=1.
- Retire:
  - head_done = head_valid & (head type==other | (lsu_resp_valid_i & lsu_resp_ready_o)).
  - lsu_resp_ready_o = head_valid & head type is load or store.
  - The LSU holds its response until lsu_resp_ready_o=1. A response arriving while lsu_resp_ready_o=0 is ignored and must be flagged by a simulation assertion.
- Ready and enqueue:
  - ready_wb_o = (count<Depth) | head_done, so a full queue accepts an enqueue in the same cycle the head retires.
  - Enqueue writes the entry at tail. The new entry is visible to hazard logic from the next cycle.
  - Enqueue and retire in the same cycle leave count unchanged.
- Register file write (combinational from head):
  - Non-load head: rf_we_wb_o = head_done & we, with rf_wdata_wb_o = head wdata.
  - Load head: rf_we_wb_o = head_done & rf_we_lsu_i, with rf_wdata_wb_o = rf_wdata_lsu_i.
  - Store head: rf_we_wb_o = 0.
  - rf_wdata_wb_o is 0 whenever rf_we_wb_o=0.
  - rf_waddr_wb_o = head waddr.
- Hazard logic, per read port, with address 0 never matching:
  - An entry matches when it is valid, its waddr equals the address, and it has we=1 or is a load.
  - Only the youngest matching entry is considered.
  - Youngest match is a load: stall=1, fwd_valid=0.
  - Youngest match is not a load: fwd_valid=1, fwd_data = its wdata.
  - No match: all three outputs are 0.
  - An entry retiring this cycle still counts toward the match.
- Performance counters:
  - perf_instr_ret_wb_o = head_done & head count & ~(lsu_resp_valid_i & lsu_resp_err_i).
  - perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & head compressed.
- pc_wb_o = head pc, or 0 when the queue is empty.
- Latency: an entry enqueued at cycle N can retire no earlier than cycle N+1.
- Reset mid-operation: all entries are discarded and no retire occurs.

Optional Feature:
IBEX_WB_QUEUE_STATS_EN: when defined, adds two outputs:
- stat_full_stall_o [15:0]: saturating count of cycles with en_wb_i=1 & ready_wb_o=0.
- stat_max_occ_o [3:0]: high-water mark of occupancy_o.
Both reset to 0. When the macro is undefined, neither port exists and no counter logic is generated.

Test Plan:
- Depth=2, enqueue other (waddr=5, wdata=0xA5A5_0001, we=1) at cycle 0 -> cycle 1: rf_we_wb_o=1, rf_waddr_wb_o=5, instr_done_wb_o=1, occupancy_o returns to 0.
- Enqueue load to x7, then other writing x7=0x11 -> rd_addr_a_i=7 gives fwd_valid_a_o=1, fwd_data_a_o=0x11, stall_a_o=0. After the load retires with lsu data 0x22 -> rf write x7=0x22, then x7=0x11 on the next cycle.
- Fill Depth=2 with two loads, hold lsu_resp_valid_i=0 -> ready_wb_o=0. Assert lsu_resp_valid_i with en_wb_i=1 -> enqueue accepted in the same cycle, occupancy_o stays 2.
- Store at head, lsu_resp_valid_i=1 with lsu_resp_err_i=1, count=1 -> instr_done_wb_o=1, perf_instr_ret_wb_o=0, rf_we_wb_o=0.
- Depth=3, issue 7 other instructions back-to-back with we=1, waddr=1..7 -> retirements in order 1..7 across pointer wrap, with no lost or duplicated writes.
- Assert rst_ni low with 2 valid entries -> next cycle occupancy_o=0, ready_wb_o=1, and no rf_we_wb_o pulse after release.
